// File: rtl/vedic_mult_seq.sv
// Sequential signed/unsigned multiplier: one 4x4 Urdhva-Tiryagbhyam digit product per clock,
// accumulated at its digit shift, with valid/ready handshakes on operand and product sides.
//
// state  | meaning
// IDLE   | in_ready=1, waiting for operands
// CALC   | accumulating digit products, k = 0 .. N*N-1
// DONE   | out_valid=1, p held until out_ready

module vedic_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p
);

  localparam int N  = WIDTH / 4;
  localparam int NN = N * N;
  localparam int PW = 2 * WIDTH;
  localparam int KW = (NN > 1) ? $clog2(NN) : 1;
  localparam int DW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
      $error("vedic_mult_seq: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  function automatic logic [3:0] vedic2x2(input logic [1:0] x, input logic [1:0] y);
    logic [3:0] r;
    logic       c;
    r[0] = x[0] & y[0];
    r[1] = (x[1] & y[0]) ^ (x[0] & y[1]);
    c    = (x[1] & y[0]) & (x[0] & y[1]);
    r[2] = (x[1] & y[1]) ^ c;
    r[3] = (x[1] & y[1]) & c;
    return r;
  endfunction

  // Vertical and crosswise: low, cross and high 2x2 products summed at their offsets.
  function automatic logic [7:0] vedic4x4(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] ll, hl, lh, hh;
    logic [4:0] mid;
    ll  = vedic2x2(x[1:0], y[1:0]);
    hl  = vedic2x2(x[3:2], y[1:0]);
    lh  = vedic2x2(x[1:0], y[3:2]);
    hh  = vedic2x2(x[3:2], y[3:2]);
    mid = {1'b0, hl} + {1'b0, lh};
    return {4'b0, ll} + {1'b0, mid, 2'b00} + {hh, 4'b0};
  endfunction

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_m_q, a_m_d;
  logic [WIDTH-1:0] b_m_q, b_m_d;
  logic             neg_q, neg_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    p_q, p_d;
  logic [KW-1:0]    k_q, k_d;
  logic [DW-1:0]    i_q, i_d;
  logic [DW-1:0]    j_q, j_d;

  logic [3:0]       a_dig, b_dig;
  logic [7:0]       dig_prod;
  logic [DW:0]      dig_pos;
  logic [PW-1:0]    term;
  logic [PW-1:0]    sum;
  logic             accept;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign p         = p_q;
  assign accept    = in_valid && (state_q == S_IDLE);

  // i and j track k mod N and k div N so no divider is needed for non power-of-two N.
  always_comb begin
    a_dig    = 4'(a_m_q >> {i_q, 2'b00});
    b_dig    = 4'(b_m_q >> {j_q, 2'b00});
    dig_prod = vedic4x4(a_dig, b_dig);
    dig_pos  = {1'b0, i_q} + {1'b0, j_q};
    term     = PW'(dig_prod) << {dig_pos, 2'b00};
    sum      = acc_q + term;
  end

  always_comb begin
    state_d = state_q;
    a_m_d   = a_m_q;
    b_m_d   = b_m_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    p_d     = p_q;
    k_d     = k_q;
    i_d     = i_q;
    j_d     = j_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude.
          a_m_d   = (is_signed && a[WIDTH-1]) ? -a : a;
          b_m_d   = (is_signed && b[WIDTH-1]) ? -b : b;
          neg_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d   = '0;
          k_d     = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        acc_d = sum;
        k_d   = k_q + KW'(1);
        if (i_q == DW'(N - 1)) begin
          i_d = '0;
          j_d = j_q + DW'(1);
        end else begin
          i_d = i_q + DW'(1);
        end
        if (k_q == KW'(NN - 1)) begin
          p_d     = neg_q ? -sum : sum;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_m_q   <= '0;
      b_m_q   <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      p_q     <= '0;
      k_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      a_m_q   <= a_m_d;
      b_m_q   <= b_m_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
      k_q     <= k_d;
      i_q     <= i_d;
      j_q     <= j_d;
    end
  end

endmodule

// File: tb/tb_vedic_mult_seq.sv
// Directed and random bench for vedic_mult_seq at WIDTH=8 and WIDTH=16.
// Inputs are driven and outputs sampled on the falling edge.

module tb_vedic_mult_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid8 = 0, in_ready8, is_signed8 = 0, out_valid8, out_ready8 = 0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] p8;

  logic        in_valid16 = 0, in_ready16, is_signed16 = 0, out_valid16, out_ready16 = 0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [31:0] p16;

  vedic_mult_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .is_signed(is_signed8),
    .out_valid(out_valid8), .out_ready(out_ready8), .p(p8)
  );

  vedic_mult_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .is_signed(is_signed16),
    .out_valid(out_valid16), .out_ready(out_ready16), .p(p16)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [15:0] p;
    int          stall;
  } vec8_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [31:0] p;
  } vec16_t;

  vec8_t  vecs8[12];
  vec16_t vecs16[4];

  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic sv,
                      input logic [15:0] ep, input int stall, input string nm);
    int cyc;
    @(negedge clk);
    chk({nm, " in_ready idle"}, 64'(in_ready8), 64'd1);
    a8 = av; b8 = bv; is_signed8 = sv; in_valid8 = 1; out_ready8 = 0;
    @(negedge clk);
    in_valid8 = 0;
    chk({nm, " in_ready busy"}, 64'(in_ready8), 64'd0);
    cyc = 0;
    while (!out_valid8 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk({nm, " latency"}, 64'(cyc), 64'd4);
    chk({nm, " p"}, 64'(p8), 64'(ep));
    for (int s = 0; s < stall; s++) begin
      chk({nm, " stall out_valid"}, 64'(out_valid8), 64'd1);
      chk({nm, " stall in_ready"}, 64'(in_ready8), 64'd0);
      chk({nm, " stall p"}, 64'(p8), 64'(ep));
      a8 = 8'h11; b8 = 8'h22; is_signed8 = 0; in_valid8 = 1;
      @(negedge clk);
    end
    out_ready8 = 1;
    @(negedge clk);
    in_valid8 = 0; out_ready8 = 0;
    chk({nm, " post in_ready"}, 64'(in_ready8), 64'd1);
    chk({nm, " post out_valid"}, 64'(out_valid8), 64'd0);
    chk({nm, " post p held"}, 64'(p8), 64'(ep));
  endtask

  task automatic run16(input logic [15:0] av, input logic [15:0] bv, input logic sv,
                       input logic [31:0] ep, input int stall, input string nm);
    int cyc;
    @(negedge clk);
    chk({nm, " in_ready idle"}, 64'(in_ready16), 64'd1);
    a16 = av; b16 = bv; is_signed16 = sv; in_valid16 = 1; out_ready16 = 0;
    @(negedge clk);
    in_valid16 = 0;
    cyc = 0;
    while (!out_valid16 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk({nm, " latency"}, 64'(cyc), 64'd16);
    chk({nm, " p"}, 64'(p16), 64'(ep));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk({nm, " stall p"}, 64'(p16), 64'(ep));
    end
    out_ready16 = 1;
    @(negedge clk);
    out_ready16 = 0;
    chk({nm, " post in_ready"}, 64'(in_ready16), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  ra8, rb8;
    logic [15:0] ra16, rb16;
    logic signed [15:0] sp8;
    logic signed [31:0] sp16;
    logic rs;

    vecs8[0]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01, 0};
    vecs8[1]  = '{8'h80, 8'h80, 1'b1, 16'h4000, 0};
    vecs8[2]  = '{8'hFD, 8'h05, 1'b1, 16'hFFF1, 0};
    vecs8[3]  = '{8'h80, 8'h7F, 1'b1, 16'hC080, 0};
    vecs8[4]  = '{8'hFD, 8'h05, 1'b0, 16'h04F1, 0};
    vecs8[5]  = '{8'h7F, 8'h7F, 1'b1, 16'h3F01, 0};
    vecs8[6]  = '{8'hFF, 8'h01, 1'b1, 16'hFFFF, 0};
    vecs8[7]  = '{8'h00, 8'hAB, 1'b1, 16'h0000, 0};
    vecs8[8]  = '{8'h12, 8'h34, 1'b0, 16'h03A8, 0};
    vecs8[9]  = '{8'h80, 8'hFF, 1'b1, 16'h0080, 0};
    vecs8[10] = '{8'hA5, 8'h5A, 1'b0, 16'h3A02, 10};
    vecs8[11] = '{8'h0C, 8'h0B, 1'b0, 16'h0084, 3};

    vecs16[0] = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001};
    vecs16[1] = '{16'h8000, 16'hFFFF, 1'b1, 32'h00008000};
    vecs16[2] = '{16'h1234, 16'h5678, 1'b0, 32'h06260060};
    vecs16[3] = '{16'hFFFE, 16'h0003, 1'b1, 32'hFFFFFFFA};

    repeat (3) @(negedge clk);
    chk("reset in_ready8", 64'(in_ready8), 64'd1);
    chk("reset out_valid8", 64'(out_valid8), 64'd0);
    chk("reset p8", 64'(p8), 64'd0);
    chk("reset p16", 64'(p16), 64'd0);
    rst = 0;

    for (int v = 0; v < 12; v++)
      run8(vecs8[v].a, vecs8[v].b, vecs8[v].s, vecs8[v].p, vecs8[v].stall, $sformatf("v8_%0d", v));
    for (int v = 0; v < 4; v++)
      run16(vecs16[v].a, vecs16[v].b, vecs16[v].s, vecs16[v].p, 0, $sformatf("v16_%0d", v));

    // Reset two cycles into CALC must discard the operation and clear p.
    @(negedge clk);
    a8 = 8'h33; b8 = 8'h44; is_signed8 = 0; in_valid8 = 1;
    @(negedge clk);
    in_valid8 = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rst_mid in_ready", 64'(in_ready8), 64'd1);
    chk("rst_mid out_valid", 64'(out_valid8), 64'd0);
    chk("rst_mid p8", 64'(p8), 64'd0);
    chk("rst_mid p16", 64'(p16), 64'd0);
    run8(8'h0C, 8'h0B, 1'b0, 16'h0084, 0, "after_rst");

    for (int t = 0; t < 200; t++) begin
      ra8 = 8'($urandom); rb8 = 8'($urandom); rs = t[0];
      sp8 = $signed(ra8) * $signed(rb8);
      run8(ra8, rb8, rs, rs ? 16'(sp8) : 16'(ra8) * 16'(rb8), int'($urandom_range(0, 3)),
           $sformatf("rnd8_%0d", t));
    end
    for (int t = 0; t < 100; t++) begin
      ra16 = 16'($urandom); rb16 = 16'($urandom); rs = t[0];
      sp16 = $signed(ra16) * $signed(rb16);
      run16(ra16, rb16, rs, rs ? 32'(sp16) : 32'(ra16) * 32'(rb16), int'($urandom_range(0, 3)),
            $sformatf("rnd16_%0d", t));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
